// File: rtl/mix_col_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : mix_col_seq_if
//  Purpose  : Request/response bundle for the sequential MixColumns engine.
//             The round controller (master) issues a start pulse with the
//             state to be mixed; the engine (slave) returns the mixed state,
//             a busy flag and a one-cycle done pulse.
//  Signals  : start     - request pulse, state_in sampled in the same cycle
//             state_in  - 128-bit input state, column c = [127-32c -: 32]
//             inv       - inverse-transform select (MIX_COL_INV_EN only)
//             state_out - 128-bit mixed state, registered
//             busy      - request in progress
//             done      - one-cycle completion pulse
//  Options  : MIX_COL_INV_EN adds the inv signal.
//  Revision : 1.0 - initial release
// ============================================================================
interface mix_col_seq_if;
  logic         start;
  logic [127:0] state_in;
`ifdef MIX_COL_INV_EN
  logic         inv;
`endif
  logic [127:0] state_out;
  logic         busy;
  logic         done;

`ifdef MIX_COL_INV_EN
  modport master (
    output start, state_in, inv,
    input  state_out, busy, done
  );
  modport slave (
    input  start, state_in, inv,
    output state_out, busy, done
  );
`else
  modport master (
    output start, state_in,
    input  state_out, busy, done
  );
  modport slave (
    input  start, state_in,
    output state_out, busy, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mix_col_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mix_col_seq
//  Purpose  : Sequential AES MixColumns engine. A single column unit built
//             from xtime (GF(2^8) multiply-by-2) operations is time-shared
//             across the four state columns, COLS_PER_CYCLE columns per
//             clock. The mixed state is returned with a one-cycle done pulse.
//  Ports    : clk    - system clock, rising edge
//             n_rst  - asynchronous active-low reset
//             bus    - mix_col_seq_if.slave (start, state_in, [inv],
//                      state_out, busy, done)
//  Params   : COLS_PER_CYCLE - columns mixed per CALC cycle (1, 2 or 4)
//  Options  : MIX_COL_INV_EN - adds the inv select and InvMixColumns logic
//  Latency  : start in cycle T -> done in cycle T + 4/COLS_PER_CYCLE + 1
//  Revision : 1.0 - initial release
// ============================================================================
module mix_col_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  wire           clk,
  input  wire           n_rst,
  mix_col_seq_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Counter step and the counter value of the final column group. With four
  // columns per cycle both truncate to zero: the counter never moves and the
  // single CALC cycle is also the last one.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Working register viewed as four 32-bit columns. Column c of the state
  // lives in element 3-c so that column 0 occupies the most significant word.
  logic [3:0][31:0] work_q;
  logic [3:0][31:0] calc_work;
  logic [1:0]       col_cnt_q;
  logic [1:0]       grp_idx;
  logic [127:0]     state_out_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
  logic             last_grp;
`ifdef MIX_COL_INV_EN
  logic             inv_q;
`endif

  // --------------------------------------------------------------------------
  // GF(2^8) helpers
  // --------------------------------------------------------------------------
  // Multiply by 2 modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns on one column; byte a is row 0 (the MSB).
  function automatic logic [31:0] fwd_mix(input logic [31:0] col);
    logic [7:0] a, b, c, d;
    logic [7:0] a2, b2, c2, d2;
    {a, b, c, d} = col;
    a2 = xtime(a);
    b2 = xtime(b);
    c2 = xtime(c);
    d2 = xtime(d);
    fwd_mix = {a2 ^ b2 ^ b ^ c ^ d,
               a ^ b2 ^ c2 ^ c ^ d,
               a ^ b ^ c2 ^ d2 ^ d,
               a2 ^ a ^ b ^ c ^ d2};
  endfunction

`ifdef MIX_COL_INV_EN
  // Multiples {0e, 0d, 0b, 09} of one byte, built from chained xtime.
  function automatic logic [31:0] inv_coefs(input logic [7:0] v);
    logic [7:0] x2, x4, x8;
    x2 = xtime(v);
    x4 = xtime(x2);
    x8 = xtime(x4);
    inv_coefs = {x8 ^ x4 ^ x2,   // 0e
                 x8 ^ x4 ^ v,    // 0d
                 x8 ^ x2 ^ v,    // 0b
                 x8 ^ v};        // 09
  endfunction

  // InvMixColumns on one column: circulant matrix rows 0e 0b 0d 09.
  function automatic logic [31:0] inv_mix(input logic [31:0] col);
    logic [31:0] ma, mb, mc, md;
    ma = inv_coefs(col[31:24]);
    mb = inv_coefs(col[23:16]);
    mc = inv_coefs(col[15:8]);
    md = inv_coefs(col[7:0]);
    // Fields: [31:24]=0e, [23:16]=0d, [15:8]=0b, [7:0]=09
    inv_mix = {ma[31:24] ^ mb[15:8]  ^ mc[23:16] ^ md[7:0],
               ma[7:0]   ^ mb[31:24] ^ mc[15:8]  ^ md[23:16],
               ma[23:16] ^ mb[7:0]   ^ mc[31:24] ^ md[15:8],
               ma[15:8]  ^ mb[23:16] ^ mc[7:0]   ^ md[31:24]};
  endfunction
`endif

  // --------------------------------------------------------------------------
  // Column datapath: mix the current group and write it back in place
  // --------------------------------------------------------------------------
  always_comb begin
    calc_work = work_q;
    grp_idx   = '0;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      grp_idx = col_cnt_q + 2'(g);
`ifdef MIX_COL_INV_EN
      calc_work[2'd3 - grp_idx] = inv_q ? inv_mix(work_q[2'd3 - grp_idx])
                                        : fwd_mix(work_q[2'd3 - grp_idx]);
`else
      calc_work[2'd3 - grp_idx] = fwd_mix(work_q[2'd3 - grp_idx]);
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_grp = (col_cnt_q == LAST_GRP);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // start pulses here are dropped: accept stays low
        if (last_grp) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A start in the done cycle is taken exactly as from IDLE
        if (bus.start) begin
          accept  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      col_cnt_q   <= '0;
      state_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MIX_COL_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      // Flags follow the state being entered so they line up with it
      busy_q  <= (state_d == CALC);
      done_q  <= (state_d == DONE);

      if (accept) begin
        work_q    <= bus.state_in;
        col_cnt_q <= '0;
`ifdef MIX_COL_INV_EN
        inv_q     <= bus.inv;
`endif
      end else if (state_q == CALC) begin
        work_q    <= calc_work;
        col_cnt_q <= col_cnt_q + COL_STEP;
        // Result is published only on completion; it otherwise holds
        if (last_grp) begin
          state_out_q <= calc_work;
        end
      end
    end
  end

  assign bus.state_out = state_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_col_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mix_col_seq
//  Purpose  : Self-checking bench for mix_col_seq. Three instances are built
//             with COLS_PER_CYCLE = 1, 2 and 4; each has its own start line
//             and shares state_in. Results are compared against a GF(2^8)
//             matrix-multiply reference model.
//  Options  : MIX_COL_INV_EN - also exercises the inverse transform.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mix_col_seq;

  logic         clk;
  logic         n_rst;
  logic [2:0]   start_v;
  logic [127:0] state_in;
  logic         inv;
  logic [127:0] out_v  [3];
  logic         busy_v [3];
  logic         done_v [3];

  int n_vec;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mix_col_seq_if bus ();
    assign bus.start    = start_v[k];
    assign bus.state_in = state_in;
`ifdef MIX_COL_INV_EN
    assign bus.inv      = inv;
`endif
    assign out_v[k]  = bus.state_out;
    assign busy_v[k] = bus.busy;
    assign done_v[k] = bus.done;

    mix_col_seq #(.COLS_PER_CYCLE(1 << k)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
    );
  end

  // --------------------------------------------------------------------------
  // Reference model: generic GF(2^8) multiply and matrix product per column
  // --------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic [7:0] a = x;
    logic [7:0] b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic iv);
    logic [7:0] fwd [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                               '{8'h01, 8'h02, 8'h03, 8'h01},
                               '{8'h01, 8'h01, 8'h02, 8'h03},
                               '{8'h03, 8'h01, 8'h01, 8'h02}};
    logic [7:0] bwd [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                               '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                               '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                               '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    logic [127:0] o = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(iv ? bwd[r][j] : fwd[r][j], s[127 - 32*c - 8*j -: 8]);
        end
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete operation on instance k; returns the result and the number
  // of cycles from the start cycle to the done cycle.
  task automatic run_op(input int k, input logic [127:0] s, input logic iv,
                        output logic [127:0] res, output int lat);
    @(negedge clk);
    start_v[k] = 1'b1;
    state_in   = s;
    inv        = iv;
    @(negedge clk);
    start_v[k] = 1'b0;
    state_in   = rand128();
    lat        = 1;
    check("busy_on", 128'(busy_v[k]), 128'd1);
    while (!done_v[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_v[k];
    check("busy_off", 128'(busy_v[k]), 128'd0);
    @(negedge clk);
    check("done_1cyc", 128'(done_v[k]), 128'd0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  localparam logic [127:0] V_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_R1_IN   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V_R1_OUT  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

  initial begin
    logic [127:0] res;
    logic [127:0] va, vb, vc, exp_a;
    logic         iv;
    int           lat;
    int           n_done;

    n_vec    = 0;
    n_bad    = 0;
    n_rst    = 1'b0;
    start_v  = '0;
    state_in = '0;
    inv      = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_out",  out_v[k], 128'h0);
      check("rst_busy", 128'(busy_v[k]), 128'd0);
      check("rst_done", 128'(done_v[k]), 128'd0);
    end
    n_rst = 1'b1;
    @(negedge clk);

    // Known forward vector, one column per cycle
    run_op(0, V_FWD_IN, 1'b0, res, lat);
    check("fwd_vec", res, V_FWD_OUT);
    check("fwd_lat", 128'(lat), 128'd5);

    // FIPS-197 round-1 vector across the parameter sweep
    for (int k = 0; k < 3; k++) begin
      run_op(k, V_R1_IN, 1'b0, res, lat);
      check("r1_vec", res, V_R1_OUT);
      check("r1_lat", 128'(lat), 128'(4 / (1 << k) + 1));
    end

`ifdef MIX_COL_INV_EN
    for (int k = 0; k < 3; k++) begin
      run_op(k, V_FWD_OUT, 1'b1, res, lat);
      check("inv_vec", res, V_FWD_IN);
      check("inv_lat", 128'(lat), 128'(4 / (1 << k) + 1));
    end
    run_op(0, V_FWD_IN, 1'b0, res, lat);
    check("fwd_after_inv", res, V_FWD_OUT);
`endif

    // Ignored start during CALC, then a start in the DONE cycle
    va    = rand128();
    vb    = rand128();
    vc    = rand128();
    exp_a = mix_ref(va, 1'b0);
    @(negedge clk);
    start_v[0] = 1'b1;
    state_in   = va;
    inv        = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    state_in   = vb;
    lat        = 1;
    @(negedge clk);
    lat        = 2;
    start_v[0] = 1'b1;
    @(negedge clk);
    lat        = 3;
    start_v[0] = 1'b0;
    state_in   = rand128();
    while (!done_v[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_lat", 128'(lat), 128'd5);
    check("ign_vec", out_v[0], exp_a);
    start_v[0] = 1'b1;
    state_in   = vc;
    @(negedge clk);
    start_v[0] = 1'b0;
    state_in   = rand128();
    check("b2b_no_2nd_done", 128'(done_v[0]), 128'd0);
    check("b2b_out_held", out_v[0], exp_a);
    lat = 1;
    while (!done_v[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat", 128'(lat), 128'd5);
    check("b2b_vec", out_v[0], mix_ref(vc, 1'b0));
    @(negedge clk);

    // Randomised operations on every instance
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        va = rand128();
`ifdef MIX_COL_INV_EN
        iv = 1'($urandom_range(0, 1));
`else
        iv = 1'b0;
`endif
        run_op(k, va, iv, res, lat);
        check("rnd_vec", res, mix_ref(va, iv));
        check("rnd_lat", 128'(lat), 128'(4 / (1 << k) + 1));
      end
    end

    // Reset during CALC aborts the operation
    @(negedge clk);
    start_v[0] = 1'b1;
    state_in   = rand128();
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("abort_busy", 128'(busy_v[0]), 128'd0);
    check("abort_out",  out_v[0], 128'h0);
    @(negedge clk);
    n_rst  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_v[0]) n_done++;
    end
    check("abort_no_done", 128'(n_done), 128'd0);
    check("abort_idle_busy", 128'(busy_v[0]), 128'd0);

    // Engine recovers with a fresh request
    va = rand128();
    run_op(0, va, 1'b0, res, lat);
    check("post_rst_vec", res, mix_ref(va, 1'b0));
    check("post_rst_lat", 128'(lat), 128'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
